systolic_feeder_2x2: RTL and testbench
======================================

# systolic_feeder_2x2

Edge driver for the 2x2 output-stationary systolic MAC array. It holds operand matrices A and B (2x2, 8-bit elements) written through a simple register port. On `start` it clears the array accumulators, then emits the row streams of A and the column streams of B with diagonal skew and zero padding on the array's left and top edges. When the last product has been accumulated it raises a one-cycle `done`; results C = A·B (each element mod 256) can then be read from the PE `out` ports.

## Interface
Parameters:
- `W`, 8, operand/stream width; must match the PE data width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  matrix write strobe.
- `wr_sel`  in  1  0 = write A, 1 = write B.
- `wr_addr`  in  2  {row, col} element index.
- `wr_data`  in  W  element value.
- `start`  in  1  request one matrix multiply.
- `busy`  out  1  high from the cycle after `start` acceptance through DRAIN.
- `done`  out  1  one-cycle pulse after DRAIN.
- `pe_clr`  out  1  one-cycle accumulator clear to the array (ORed into PE reset by the top level).
- `valid`  out  1  high during FEED cycles.
- `a_row0`, `a_row1`  out  W  left-edge `in_a` for array rows 0 and 1.
- `b_col0`, `b_col1`  out  W  top-edge `in_b` for array columns 0 and 1.

All outputs are registered. Reset value is 0 for every output and every storage element.

## Operation
- Storage: `wr_en` in IDLE writes `A[row][col]` or `B[row][col]` at the rising edge. A write and a `start` in the same cycle: the write lands first and is used by that run.
- States: IDLE → CLR → FEED → DRAIN → IDLE.
  - IDLE: `busy`=0. `start`=1 → CLR.
  - CLR: one cycle, `pe_clr`=1, `busy`=1 → FEED, with f=0.
  - FEED: four cycles, f=0..3, `valid`=1.
    - `a_rowi` = A[i][f−i] if 0 ≤ f−i ≤ 1, else 0.
    - `b_colj` = B[f−j][j] if 0 ≤ f−j ≤ 1, else 0.
    - f=3 emits all zeros, which flushes the skew.
    - f=3 → DRAIN.
  - DRAIN: one cycle, `busy`=1, all streams 0 → IDLE. In the following cycle `done`=1 and `busy`=0.
- `start` while `busy`=1 is ignored and not queued. `start` in the `done` cycle is accepted, because the state is IDLE.
- `wr_en` while `busy`=1 is ignored, unless the macro below is defined.
- Arithmetic: the feeder does no arithmetic. Array results wrap mod 2^W, because each PE truncates its product and sum to W bits.
- Reset mid-run: outputs are forced to 0 immediately (asynchronously) and the state goes to IDLE. No `done` is issued for the aborted run. Stored matrices are cleared.

## Timing
- `start` is sampled at edge T0.
- `pe_clr` is high in cycle T0+1.
- FEED covers T0+2..T0+5.
- DRAIN is T0+6. `done` is high in T0+7.
- PE(1,1) performs its final accumulate at the edge ending T0+5. All PE `out` values are stable from T0+6.
- Back-to-back runs: `start` in the `done` cycle gives a throughput of one multiply per 7 cycles.

## Configuration
- `FEEDER_DOUBLE_BUF_EN` defined:
  - A and B are double-banked.
  - `wr_en` always writes the shadow bank, including while `busy`=1.
  - Accepting `start` copies shadow → active in the same edge. A write in that same cycle is included in the copy.
  - FEED reads only the active bank.
- `FEEDER_DOUBLE_BUF_EN` undefined:
  - Single bank.
  - Writes while `busy`=1 are dropped.

## Test plan
- Reset: assert `reset` mid-FEED → all outputs 0 in the same cycle. After release, `busy`=0, no `done`, and reading A/B back via a run gives all-zero streams.
- Basic stream: A=[[1,2],[3,4]], B=[[5,6],[7,8]], `start` → expected edge values:
  - f0: a=(1,0), b=(5,0).
  - f1: a=(2,3), b=(7,6).
  - f2: a=(0,4), b=(0,8).
  - f3: all 0.
  - With the 2x2 PE array attached, C=[[19,22],[43,50]] at T0+6 and `done` at T0+7.
- Wrap: all A and B elements = 255 → every C element = 2, since each 255·255 product truncates to 1 and two accumulate.
- Ignored start: pulse `start` at T0+3 → no restart. `done` at T0+7 only, and `pe_clr` pulses once.
- Back-to-back: `start` held high continuously → `pe_clr` at T0+1 and T0+8, `done` at T0+7 and T0+14.
- Busy writes: write A[0][0]=9 during FEED.
  - Macro undefined: the next run still uses the old value.
  - Macro defined: the current run is unchanged, and the next run emits 9 at f0 on `a_row0`.

Source files
------------

// File: rtl/systolic_feeder_2x2_if.sv
// Bundle between the 2x2 systolic feeder and its driver/array edge.
// Carries matrix writes and start in; status pulses and skewed streams out.
interface systolic_feeder_2x2_if #(
   parameter int W = 8
);
   logic         wr_en;
   logic         wr_sel;
   logic [1:0]   wr_addr;
   logic [W-1:0] wr_data;
   logic         start;
   logic         busy;
   logic         done;
   logic         pe_clr;
   logic         valid;
   logic [W-1:0] a_row0;
   logic [W-1:0] a_row1;
   logic [W-1:0] b_col0;
   logic [W-1:0] b_col1;

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, start,
      input  busy, done, pe_clr, valid,
      input  a_row0, a_row1, b_col0, b_col1
   );

   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, start,
      output busy, done, pe_clr, valid,
      output a_row0, a_row1, b_col0, b_col1
   );
endinterface

// File: rtl/systolic_feeder_2x2.sv
// Edge driver for a 2x2 output-stationary MAC array: stores A/B, clears,
// streams skewed rows/cols, pulses done. Ports: clk, reset, bus (slave).
// Option macro FEEDER_DOUBLE_BUF_EN: shadow/active banks for A and B.
module systolic_feeder_2x2 #(
   parameter int W = 8
) (
   input logic              clk,
   input logic              reset,
   systolic_feeder_2x2_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CLR, FEED, DRAIN} state_t;

   state_t state_q, state_d;
   logic [1:0] f_q, f_d;

   // element index is {row, col}
   logic [3:0][W-1:0] a_q, a_d;
   logic [3:0][W-1:0] b_q, b_d;

   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         clr_q, clr_d;
   logic         valid_q, valid_d;
   logic [W-1:0] a0_q, a0_d, a1_q, a1_d;
   logic [W-1:0] b0_q, b0_d, b1_q, b1_d;

   logic accept;
   assign accept = (state_q == IDLE) && bus.start;

   always_comb begin
      state_d = state_q;
      f_d     = f_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = CLR;
         CLR: begin
            state_d = FEED;
            f_d     = 2'd0;
         end
         FEED: begin
            f_d = f_q + 2'd1;
            if (f_q == 2'd3) state_d = DRAIN;
         end
         DRAIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef FEEDER_DOUBLE_BUF_EN
   logic [3:0][W-1:0] sa_q, sa_d;
   logic [3:0][W-1:0] sb_q, sb_d;

   // the copy takes the merged shadow so a same-cycle write is included
   always_comb begin
      sa_d = sa_q;
      sb_d = sb_q;
      if (bus.wr_en) begin
         if (bus.wr_sel) sb_d[bus.wr_addr] = bus.wr_data;
         else            sa_d[bus.wr_addr] = bus.wr_data;
      end
      a_d = a_q;
      b_d = b_q;
      if (accept) begin
         a_d = sa_d;
         b_d = sb_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sa_q <= '0;
         sb_q <= '0;
      end else begin
         sa_q <= sa_d;
         sb_q <= sb_d;
      end
   end
`else
   always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (bus.wr_en && state_q == IDLE) begin
         if (bus.wr_sel) b_d[bus.wr_addr] = bus.wr_data;
         else            a_d[bus.wr_addr] = bus.wr_data;
      end
   end
`endif

   // outputs are registered, so decode from the state being entered
   always_comb begin
      busy_d  = (state_d != IDLE);
      clr_d   = (state_d == CLR);
      valid_d = (state_d == FEED);
      done_d  = (state_q == DRAIN);
      a0_d    = '0;
      a1_d    = '0;
      b0_d    = '0;
      b1_d    = '0;
      if (state_d == FEED) begin
         unique case (f_d)
            2'd0: begin
               a0_d = a_q[0];
               b0_d = b_q[0];
            end
            2'd1: begin
               a0_d = a_q[1];
               a1_d = a_q[2];
               b0_d = b_q[2];
               b1_d = b_q[1];
            end
            2'd2: begin
               a1_d = a_q[3];
               b1_d = b_q[3];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         f_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         clr_q   <= 1'b0;
         valid_q <= 1'b0;
         a0_q    <= '0;
         a1_q    <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
      end else begin
         state_q <= state_d;
         f_q     <= f_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         clr_q   <= clr_d;
         valid_q <= valid_d;
         a0_q    <= a0_d;
         a1_q    <= a1_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.pe_clr = clr_q;
   assign bus.valid  = valid_q;
   assign bus.a_row0 = a0_q;
   assign bus.a_row1 = a1_q;
   assign bus.b_col0 = b0_q;
   assign bus.b_col1 = b1_q;

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Bench for systolic_feeder_2x2: stream scoreboard plus a 2x2 PE array
// model checking C, status timing, reset abort and busy writes.
module tb_systolic_feeder_2x2;
   localparam int W = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   systolic_feeder_2x2_if #(.W(W)) fif ();

   systolic_feeder_2x2 #(.W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (fif)
   );

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [7:0] a0;
      logic [7:0] a1;
      logic [7:0] b0;
      logic [7:0] b1;
   } vec_t;

   vec_t exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic vec_t v(input int a0, input int a1,
                              input int b0, input int b1);
      vec_t r;
      r.a0 = 8'(a0);
      r.a1 = 8'(a1);
      r.b0 = 8'(b0);
      r.b1 = 8'(b1);
      return r;
   endfunction

   // monitor: every valid cycle must match the next expected vector
   always @(negedge clk) begin
      vec_t got;
      vec_t e;
      if (!reset && fif.valid) begin
         got = {fif.a_row0, fif.a_row1, fif.b_col0, fif.b_col1};
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL stream_extra actual=%0h required=none", got);
         end else begin
            e = exp_q.pop_front();
            chk("stream", got, e);
         end
      end
   end

   // behavioural 2x2 output-stationary array, W-bit wrap
   logic [7:0] c00, c01, c10, c11;
   logic [7:0] pa00, pb00, pa10, pb01;
   always @(posedge clk or posedge reset) begin
      if (reset || fif.pe_clr) begin
         c00 <= 0; c01 <= 0; c10 <= 0; c11 <= 0;
         pa00 <= 0; pb00 <= 0; pa10 <= 0; pb01 <= 0;
      end else begin
         c00  <= c00 + fif.a_row0 * fif.b_col0;
         c01  <= c01 + pa00 * fif.b_col1;
         c10  <= c10 + fif.a_row1 * pb00;
         c11  <= c11 + pa10 * pb01;
         pa00 <= fif.a_row0;
         pb00 <= fif.b_col0;
         pa10 <= fif.a_row1;
         pb01 <= fif.b_col1;
      end
   end

   // {busy, pe_clr, valid, done} k cycles after the start edge
   function automatic logic [3:0] st(input int k);
      if (k == 1)           return 4'b1100;
      if (k >= 2 && k <= 5) return 4'b1010;
      if (k == 6)           return 4'b1000;
      if (k == 7)           return 4'b0001;
      return 4'b0000;
   endfunction

   task automatic wr(input logic sel, input logic [1:0] addr,
                     input logic [7:0] d);
      fif.wr_en   = 1'b1;
      fif.wr_sel  = sel;
      fif.wr_addr = addr;
      fif.wr_data = d;
      @(negedge clk);
      fif.wr_en = 1'b0;
   endtask

   task automatic push_basic();
      exp_q.push_back(v(1, 0, 5, 0));
      exp_q.push_back(v(2, 3, 7, 6));
      exp_q.push_back(v(0, 4, 0, 8));
      exp_q.push_back(v(0, 0, 0, 0));
   endtask

   task automatic chk_c(input int e00, input int e01,
                        input int e10, input int e11);
      chk("c00", c00, e00);
      chk("c01", c01, e01);
      chk("c10", c10, e10);
      chk("c11", c11, e11);
   endtask

   // called at a negedge; start is sampled at the next posedge (T0)
   task automatic do_run(input int ncyc, input int pulse_k, input bit hold,
                         input int wk, input logic wsel,
                         input logic [1:0] waddr, input logic [7:0] wdata,
                         input int e00, input int e01,
                         input int e10, input int e11);
      fif.start = 1'b1;
      if (wk == 0) begin
         fif.wr_en   = 1'b1;
         fif.wr_sel  = wsel;
         fif.wr_addr = waddr;
         fif.wr_data = wdata;
      end
      for (int k = 1; k <= ncyc; k++) begin
         logic [3:0] e;
         @(negedge clk);
         if (k == 1) fif.wr_en = 1'b0;
         if (k == 1 && !hold) fif.start = 1'b0;
         if (k == 8 && hold) fif.start = 1'b0;
         e = (k <= 7) ? st(k) : (hold ? st(k - 7) : 4'b0000);
         chk($sformatf("status_k%0d", k),
             {fif.busy, fif.pe_clr, fif.valid, fif.done}, e);
         if (k == 6 || (hold && k == 13)) chk_c(e00, e01, e10, e11);
         if (k == pulse_k) fif.start = 1'b1;
         if (k == pulse_k + 1) fif.start = 1'b0;
         if (k == wk) begin
            fif.wr_en   = 1'b1;
            fif.wr_sel  = wsel;
            fif.wr_addr = waddr;
            fif.wr_data = wdata;
         end
         if (wk > 0 && k == wk + 1) fif.wr_en = 1'b0;
      end
   endtask

   initial begin
      fif.wr_en   = 1'b0;
      fif.wr_sel  = 1'b0;
      fif.wr_addr = 2'd0;
      fif.wr_data = 8'd0;
      fif.start   = 1'b0;
      reset       = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_status", {fif.busy, fif.pe_clr, fif.valid, fif.done}, 0);
      chk("rst_streams",
          {fif.a_row0, fif.a_row1, fif.b_col0, fif.b_col1}, 0);
      reset = 1'b0;
      @(negedge clk);

      wr(0, 0, 1); wr(0, 1, 2); wr(0, 2, 3); wr(0, 3, 4);
      wr(1, 0, 5); wr(1, 1, 6); wr(1, 2, 7); wr(1, 3, 8);

      // basic stream
      push_basic();
      do_run(7, -1, 0, -1, 0, 0, 0, 19, 22, 43, 50);

      // start during FEED is ignored
      push_basic();
      do_run(9, 3, 0, -1, 0, 0, 0, 19, 22, 43, 50);

      // start held high: back-to-back runs
      push_basic();
      push_basic();
      do_run(14, -1, 1, -1, 0, 0, 0, 19, 22, 43, 50);

      // write A[0][0]=9 during FEED; current run unchanged
      push_basic();
      do_run(7, -1, 0, 3, 0, 2'd0, 8'd9, 19, 22, 43, 50);
`ifdef FEEDER_DOUBLE_BUF_EN
      exp_q.push_back(v(9, 0, 5, 0));
      exp_q.push_back(v(2, 3, 7, 6));
      exp_q.push_back(v(0, 4, 0, 8));
      exp_q.push_back(v(0, 0, 0, 0));
      do_run(7, -1, 0, -1, 0, 0, 0, 59, 70, 43, 50);
`else
      push_basic();
      do_run(7, -1, 0, -1, 0, 0, 0, 19, 22, 43, 50);
`endif

      // wrap: all 255, last element written in the start cycle
      wr(0, 0, 255); wr(0, 1, 255); wr(0, 2, 255);
      wr(1, 0, 255); wr(1, 1, 255); wr(1, 2, 255); wr(1, 3, 255);
      exp_q.push_back(v(255, 0, 255, 0));
      exp_q.push_back(v(255, 255, 255, 255));
      exp_q.push_back(v(0, 255, 0, 255));
      exp_q.push_back(v(0, 0, 0, 0));
      do_run(7, -1, 0, 0, 0, 2'd3, 8'd255, 2, 2, 2, 2);

      // reset in the middle of FEED
      exp_q.push_back(v(255, 0, 255, 0));
      exp_q.push_back(v(255, 255, 255, 255));
      fif.start = 1'b1;
      @(negedge clk);
      fif.start = 1'b0;
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("abort_status", {fif.busy, fif.pe_clr, fif.valid, fif.done}, 0);
      chk("abort_streams",
          {fif.a_row0, fif.a_row1, fif.b_col0, fif.b_col1}, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_abort_idle",
             {fif.busy, fif.pe_clr, fif.valid, fif.done}, 0);
      end

      // matrices were cleared by reset
      repeat (4) exp_q.push_back(v(0, 0, 0, 0));
      do_run(7, -1, 0, -1, 0, 0, 0, 0, 0, 0, 0);

      @(negedge clk);
      chk("exp_q_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
